// File: rtl/decode_writeback.sv
// decode_writeback
//   Y86-64 SEQ decode and write-back stage with the fifteen 64-bit program
//   registers. Decodes source/destination register IDs from the fetched
//   instruction, reads valA/valB combinationally, and commits valE/valM on
//   the rising clock edge.
//
// Parameters
//   RSP_INIT : value loaded into %rsp (ID 4) on reset
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   icode, ifun, rA, rB   : fields from fetch (ifun has no decode effect)
//   cnd                   : execute condition, gates the cmovXX dstE write
//   wb_en                 : write-back enable; low suppresses all writes
//   valE, valM            : write-back data for dstE and dstM
//   valA, valB            : register contents of srcA/srcB (0 for ID F)
//   srcA, srcB, dstE, dstM: decoded register IDs (F = none)
module decode_writeback #(
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic        wb_en,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    // ifun carries no information for this stage
    logic ifun_unused;
    assign ifun_unused = ^ifun;

    logic [63:0] regs [0:14];

    // ------------------------------------------------------------------
    // Register ID decode
    // ------------------------------------------------------------------
    always_comb begin
        srcA = R_NONE;
        srcB = R_NONE;
        dstE = R_NONE;
        dstM = R_NONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                // cmovXX with a false condition writes nothing
                dstE = cnd ? rB : R_NONE;
            end
            I_IRMOVQ: begin
                dstE = rB;
            end
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = R_RSP;
                dstE = R_RSP;
            end
            I_RET: begin
                srcA = R_RSP;
                srcB = R_RSP;
                dstE = R_RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = R_RSP;
                dstE = R_RSP;
            end
            I_POPQ: begin
                srcA = R_RSP;
                srcB = R_RSP;
                dstE = R_RSP;
                dstM = rA;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational register reads (pre-write state, no bypass)
    // ------------------------------------------------------------------
    always_comb begin
        valA = '0;
        valB = '0;
        if (srcA != R_NONE) valA = regs[srcA];
        if (srcB != R_NONE) valB = regs[srcB];
    end

    // ------------------------------------------------------------------
    // Write-back
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 15; i++) begin
                regs[i] <= (i == 4) ? RSP_INIT : '0;
            end
        end else if (wb_en) begin
            // dstM is written last so it overrides dstE when both target
            // the same register (popq %rsp)
            if (dstE != R_NONE) regs[dstE] <= valE;
            if (dstM != R_NONE) regs[dstM] <= valM;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
module tb_decode_writeback;

    localparam logic [63:0] RSP0 = 64'h200;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode, ifun, rA, rB;
    logic        cnd, wb_en;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB;
    logic [3:0]  srcA, srcB, dstE, dstM;

    decode_writeback #(.RSP_INIT(RSP0)) dut (
        .clk(clk), .rst_n(rst_n),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .cnd(cnd), .wb_en(wb_en), .valE(valE), .valM(valM),
        .valA(valA), .valB(valB),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // selectors for which DUT output an expectation refers to
    localparam int unsigned S_VALA = 0, S_VALB = 1, S_SRCA = 2,
                            S_SRCB = 3, S_DSTE = 4, S_DSTM = 5;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    event check_ev;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [63:0] pick(int unsigned sel);
        case (sel)
            S_VALA:  return valA;
            S_VALB:  return valB;
            S_SRCA:  return {60'd0, srcA};
            S_SRCB:  return {60'd0, srcB};
            S_DSTE:  return {60'd0, dstE};
            default: return {60'd0, dstM};
        endcase
    endfunction

    // monitor: drains the scoreboard whenever the stimulus says outputs are valid
    initial begin
        exp_t e;
        logic [63:0] act;
        forever begin
            @(check_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = pick(e.sel);
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int unsigned sel,
                              input logic [63:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic expect_ids(input string name, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] de,
                              input logic [3:0] dm);
        expect_val({name, ".srcA"}, S_SRCA, {60'd0, a});
        expect_val({name, ".srcB"}, S_SRCB, {60'd0, b});
        expect_val({name, ".dstE"}, S_DSTE, {60'd0, de});
        expect_val({name, ".dstM"}, S_DSTM, {60'd0, dm});
    endtask

    task automatic sample();
        #1;
        -> check_ev;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c, input logic we,
                         input logic [63:0] e, input logic [63:0] m);
        icode = ic; rA = a; rB = b; cnd = c; wb_en = we; valE = e; valM = m;
    endtask

    // observe a register through valA using OPq with rB = F, no write
    task automatic read_reg(input string name, input logic [3:0] r,
                            input logic [63:0] exp);
        drive(4'h6, r, 4'hF, 1'b0, 1'b0, 64'h0, 64'h0);
        expect_val(name, S_VALA, exp);
        sample();
    endtask

    initial begin
        ifun  = 4'h0;
        rst_n = 1'b0;
        // a write attempted during reset must not land
        drive(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 64'h99, 64'h0);
        step();
        step();
        drive(4'h6, 4'h4, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        expect_val("rst.valA_rsp", S_VALA, RSP0);
        expect_val("rst.valB_rax", S_VALB, 64'h0);
        expect_ids("rst.opq", 4'h4, 4'h0, 4'h0, 4'hF);
        sample();
        read_reg("rst.rdx", 4'h2, 64'h0);
        rst_n = 1'b1;

        drive(4'h0, 4'h1, 4'h2, 1'b1, 1'b1, 64'h1, 64'h2);
        expect_ids("halt", 4'hF, 4'hF, 4'hF, 4'hF);
        expect_val("halt.valA", S_VALA, 64'h0);
        sample();

        // irmovq $0x0A, %rdx
        step();
        drive(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 64'h0A, 64'h0);
        expect_ids("irmovq", 4'hF, 4'hF, 4'h2, 4'hF);
        sample();
        step();
        // addq %rdx, %rdx: reads old value, no bypass
        drive(4'h6, 4'h2, 4'h2, 1'b0, 1'b1, 64'h14, 64'h0);
        expect_val("addq.valA", S_VALA, 64'h0A);
        expect_val("addq.valB", S_VALB, 64'h0A);
        expect_ids("addq", 4'h2, 4'h2, 4'h2, 4'hF);
        sample();
        step();
        read_reg("addq.rdx", 4'h2, 64'h14);

        // cmovXX %rcx, %rbx
        drive(4'h2, 4'h1, 4'h3, 1'b0, 1'b1, 64'h55, 64'h0);
        expect_ids("cmov_nc", 4'h1, 4'hF, 4'hF, 4'hF);
        sample();
        step();
        read_reg("cmov_nc.rbx", 4'h3, 64'h0);
        drive(4'h2, 4'h1, 4'h3, 1'b1, 1'b1, 64'h55, 64'h0);
        expect_ids("cmov_c", 4'h1, 4'hF, 4'h3, 4'hF);
        sample();
        step();
        read_reg("cmov_c.rbx", 4'h3, 64'h55);

        // popq %rsp: valM wins over valE
        drive(4'hB, 4'h4, 4'hF, 1'b0, 1'b1, 64'h208, 64'hDEAD);
        expect_ids("popq", 4'h4, 4'h4, 4'h4, 4'h4);
        expect_val("popq.valA", S_VALA, RSP0);
        sample();
        step();
        read_reg("popq.rsp", 4'h4, 64'hDEAD);

        // call
        drive(4'h8, 4'hF, 4'hF, 1'b0, 1'b1, 64'h1F0, 64'h0);
        expect_ids("call", 4'hF, 4'h4, 4'h4, 4'hF);
        expect_val("call.valB", S_VALB, 64'hDEAD);
        sample();
        step();
        read_reg("call.rsp", 4'h4, 64'h1F0);

        // mrmovq D(%rsi), %rdi
        drive(4'h5, 4'h7, 4'h6, 1'b0, 1'b1, 64'h123, 64'h77);
        expect_ids("mrmovq", 4'hF, 4'h6, 4'hF, 4'h7);
        expect_val("mrmovq.valB", S_VALB, 64'h0);
        sample();
        step();
        read_reg("mrmovq.rdi", 4'h7, 64'h77);
        read_reg("mrmovq.rsi", 4'h6, 64'h0);

        // decode-only patterns, writes suppressed
        drive(4'h4, 4'h1, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
        expect_ids("rmmovq", 4'h1, 4'h2, 4'hF, 4'hF);
        expect_val("rmmovq.valB", S_VALB, 64'h14);
        sample();
        drive(4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 64'h0, 64'h0);
        expect_ids("pushq", 4'h5, 4'h4, 4'h4, 4'hF);
        sample();
        drive(4'h9, 4'hF, 4'hF, 1'b1, 1'b0, 64'h0, 64'h0);
        expect_ids("ret", 4'h4, 4'h4, 4'h4, 4'hF);
        sample();
        drive(4'h7, 4'h1, 4'h2, 1'b1, 1'b0, 64'h0, 64'h0);
        expect_ids("jxx", 4'hF, 4'hF, 4'hF, 4'hF);
        sample();
        drive(4'hC, 4'h1, 4'h2, 1'b1, 1'b1, 64'h0, 64'h0);
        expect_ids("icodeC", 4'hF, 4'hF, 4'hF, 4'hF);
        sample();
        read_reg("idF.valA", 4'hF, 64'h0);

        // wb_en gating, then asynchronous reset mid-cycle
        drive(4'h3, 4'hF, 4'h1, 1'b0, 1'b1, 64'h11, 64'h0);
        step();
        read_reg("wb.rcx", 4'h1, 64'h11);
        drive(4'h3, 4'hF, 4'h1, 1'b0, 1'b0, 64'hFF, 64'h0);
        step();
        read_reg("nowb.rcx", 4'h1, 64'h11);
        rst_n = 1'b0;
        read_reg("arst.rcx", 4'h1, 64'h0);
        read_reg("arst.rsp", 4'h4, RSP0);
        read_reg("arst.rdi", 4'h7, 64'h0);
        step();
        rst_n = 1'b1;

        // bounded drain of anything the monitor has not consumed
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            -> check_ev;
            #1;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
